// File: rtl/hp0_axi_dram_gate.sv
// HP0 AXI4 gate: rebases AR/AW into the DRAM carve-out, caps outstanding bursts, orders W after AW; HP0_AXI_DRAM_GATE_PERF_EN adds perf counters.
// Latency: zero cycles on every valid/ready/data path; only the counters and status flags are registered.
// Backpressure: AR/AW close at the outstanding cap or when disabled, W closes without AW credit; R/B pass straight through.
module hp0_axi_dram_gate #(
    parameter int                      addr_width_p = 32,
    parameter int                      data_width_p = 64,
    parameter int                      id_width_p   = 6,
    parameter int                      max_out_p    = 8,
    parameter logic [addr_width_p-1:0] win_base_p   = 32'h1000_0000,
    parameter logic [addr_width_p-1:0] win_size_p   = 32'h1000_0000
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable_i,

    input  logic [id_width_p-1:0]       s_axi_awid,
    input  logic [addr_width_p-1:0]     s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awlock,
    input  logic [3:0]                  s_axi_awcache,
    input  logic [2:0]                  s_axi_awprot,
    input  logic [3:0]                  s_axi_awqos,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [data_width_p-1:0]     s_axi_wdata,
    input  logic [data_width_p/8-1:0]   s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [id_width_p-1:0]       s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [id_width_p-1:0]       s_axi_arid,
    input  logic [addr_width_p-1:0]     s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arlock,
    input  logic [3:0]                  s_axi_arcache,
    input  logic [2:0]                  s_axi_arprot,
    input  logic [3:0]                  s_axi_arqos,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [id_width_p-1:0]       s_axi_rid,
    output logic [data_width_p-1:0]     s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,

    output logic [id_width_p-1:0]       m_axi_awid,
    output logic [addr_width_p-1:0]     m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [data_width_p-1:0]     m_axi_wdata,
    output logic [data_width_p/8-1:0]   m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [id_width_p-1:0]       m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [id_width_p-1:0]       m_axi_arid,
    output logic [addr_width_p-1:0]     m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arqos,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [id_width_p-1:0]       m_axi_rid,
    input  logic [data_width_p-1:0]     m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,

    output logic                        idle_o,
    output logic [1:0]                  err_o,
    output logic                        proto_err_o,
    output logic [31:0]                 rd_bursts_o,
    output logic [31:0]                 wr_bursts_o,
    output logic [31:0]                 stall_cyc_o
);

    localparam int                      cnt_w_c    = $clog2(max_out_p + 1);
    localparam logic [cnt_w_c-1:0]      cnt_max_c  = cnt_w_c'(max_out_p);
    localparam logic [addr_width_p-1:0] win_mask_c = win_size_p - 1'b1;

    logic [cnt_w_c-1:0] rd_cnt_q, rd_cnt_d;
    logic [cnt_w_c-1:0] wr_cnt_q, wr_cnt_d;
    logic [cnt_w_c-1:0] w_cred_q, w_cred_d;
    logic [1:0]         err_q, err_d;
    logic               proto_err_q, proto_err_d;

    logic ar_ok, aw_ok, w_ok;
    logic ar_hs, aw_hs, w_last_hs, r_hs, r_last_hs, b_hs;

    // Simultaneous inc/dec cancels; a dec at zero is absorbed (flagged separately).
    function automatic logic [cnt_w_c-1:0] cnt_next(input logic [cnt_w_c-1:0] cur,
                                                    input logic inc, input logic dec);
        if (inc && !dec)
            cnt_next = cur + cnt_w_c'(1);
        else if (dec && !inc && cur != '0)
            cnt_next = cur - cnt_w_c'(1);
        else
            cnt_next = cur;
    endfunction

    // Gates use the registered counts, so a completion only reopens a direction next cycle.
    always_comb begin
        ar_ok = aresetn & enable_i & (rd_cnt_q != cnt_max_c);
        aw_ok = aresetn & enable_i & (wr_cnt_q != cnt_max_c);
        w_ok  = aresetn & (w_cred_q != '0);
    end

    assign m_axi_arvalid = s_axi_arvalid & ar_ok;
    assign s_axi_arready = m_axi_arready & ar_ok;
    assign m_axi_awvalid = s_axi_awvalid & aw_ok;
    assign s_axi_awready = m_axi_awready & aw_ok;
    assign m_axi_wvalid  = s_axi_wvalid & w_ok;
    assign s_axi_wready  = m_axi_wready & w_ok;

    assign m_axi_araddr  = win_base_p | (s_axi_araddr & win_mask_c);
    assign m_axi_awaddr  = win_base_p | (s_axi_awaddr & win_mask_c);

    assign m_axi_arid    = s_axi_arid;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;

    assign s_axi_rid     = m_axi_rid;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rvalid  = m_axi_rvalid;
    assign m_axi_rready  = s_axi_rready;
    assign s_axi_bid     = m_axi_bid;
    assign s_axi_bresp   = m_axi_bresp;
    assign s_axi_bvalid  = m_axi_bvalid;
    assign m_axi_bready  = s_axi_bready;

    always_comb begin
        ar_hs     = m_axi_arvalid & m_axi_arready;
        aw_hs     = m_axi_awvalid & m_axi_awready;
        w_last_hs = m_axi_wvalid & m_axi_wready & m_axi_wlast;
        r_hs      = m_axi_rvalid & s_axi_rready;
        r_last_hs = r_hs & m_axi_rlast;
        b_hs      = m_axi_bvalid & s_axi_bready;
    end

    always_comb begin
        rd_cnt_d    = cnt_next(rd_cnt_q, ar_hs, r_last_hs);
        wr_cnt_d    = cnt_next(wr_cnt_q, aw_hs, b_hs);
        w_cred_d    = cnt_next(w_cred_q, aw_hs, w_last_hs);
        err_d       = err_q | {b_hs & (m_axi_bresp != 2'b00), r_hs & (m_axi_rresp != 2'b00)};
        proto_err_d = proto_err_q | (r_last_hs & (rd_cnt_q == '0)) | (b_hs & (wr_cnt_q == '0));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            w_cred_q    <= '0;
            err_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            w_cred_q    <= w_cred_d;
            err_q       <= err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign idle_o      = (rd_cnt_q == '0) & (wr_cnt_q == '0) & (w_cred_q == '0);
    assign err_o       = err_q;
    assign proto_err_o = proto_err_q;

`ifdef HP0_AXI_DRAM_GATE_PERF_EN
    logic [31:0] rd_bursts_q, rd_bursts_d;
    logic [31:0] wr_bursts_q, wr_bursts_d;
    logic [31:0] stall_cyc_q, stall_cyc_d;
    logic        stall_ev;

    function automatic logic [31:0] sat_inc(input logic [31:0] cur, input logic en);
        sat_inc = (en && cur != 32'hFFFF_FFFF) ? cur + 32'd1 : cur;
    endfunction

    // One stall tick per cycle, however many channels are held off.
    always_comb begin
        stall_ev    = (s_axi_arvalid & ~ar_ok) | (s_axi_awvalid & ~aw_ok) | (s_axi_wvalid & ~w_ok);
        rd_bursts_d = sat_inc(rd_bursts_q, ar_hs);
        wr_bursts_d = sat_inc(wr_bursts_q, aw_hs);
        stall_cyc_d = sat_inc(stall_cyc_q, stall_ev);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_bursts_q <= '0;
            wr_bursts_q <= '0;
            stall_cyc_q <= '0;
        end else begin
            rd_bursts_q <= rd_bursts_d;
            wr_bursts_q <= wr_bursts_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign rd_bursts_o = rd_bursts_q;
    assign wr_bursts_o = wr_bursts_q;
    assign stall_cyc_o = stall_cyc_q;
`else
    assign rd_bursts_o = '0;
    assign wr_bursts_o = '0;
    assign stall_cyc_o = '0;
`endif

endmodule

// File: tb/tb_hp0_axi_dram_gate.sv
// Bench for hp0_axi_dram_gate: directed scenarios then random traffic and a drain, each cycle checked against an outstanding-count model.
module tb_hp0_axi_dram_gate;

    localparam int         MAX      = 8;
    localparam logic [63:0] WIN_BASE = 64'h1000_0000;
    localparam logic [63:0] WIN_SIZE = 64'h1000_0000;

    logic aclk, aresetn, enable_i;
    logic [5:0]  s_axi_awid, m_axi_awid, s_axi_arid, m_axi_arid;
    logic [31:0] s_axi_awaddr, m_axi_awaddr, s_axi_araddr, m_axi_araddr;
    logic [7:0]  s_axi_awlen, m_axi_awlen, s_axi_arlen, m_axi_arlen;
    logic [2:0]  s_axi_awsize, m_axi_awsize, s_axi_arsize, m_axi_arsize;
    logic [1:0]  s_axi_awburst, m_axi_awburst, s_axi_arburst, m_axi_arburst;
    logic        s_axi_awlock, m_axi_awlock, s_axi_arlock, m_axi_arlock;
    logic [3:0]  s_axi_awcache, m_axi_awcache, s_axi_arcache, m_axi_arcache;
    logic [2:0]  s_axi_awprot, m_axi_awprot, s_axi_arprot, m_axi_arprot;
    logic [3:0]  s_axi_awqos, m_axi_awqos, s_axi_arqos, m_axi_arqos;
    logic        s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
    logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [63:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
    logic [7:0]  s_axi_wstrb, m_axi_wstrb;
    logic        s_axi_wlast, m_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
    logic [5:0]  s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
    logic [1:0]  s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
    logic        s_axi_rlast, m_axi_rlast, s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;
    logic        idle_o, proto_err_o;
    logic [1:0]  err_o;
    logic [31:0] rd_bursts_o, wr_bursts_o, stall_cyc_o;

    hp0_axi_dram_gate dut (
        .aclk(aclk), .aresetn(aresetn), .enable_i(enable_i),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .idle_o(idle_o), .err_o(err_o), .proto_err_o(proto_err_o),
        .rd_bursts_o(rd_bursts_o), .wr_bursts_o(wr_bursts_o), .stall_cyc_o(stall_cyc_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: bursts awaiting R-last / B / W-last, plus sticky flags and perf totals.
    int          mr, mw, mc;
    logic [1:0]  merr;
    logic        mproto;
    longint      prd, pwr, pst;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mr = 0; mw = 0; mc = 0; merr = 2'b00; mproto = 1'b0;
        prd = 0; pwr = 0; pst = 0;
    endtask

    task automatic model_update();
        bit ar_ok, aw_ok, w_ok, ar_hs, aw_hs, w_done, r_hs, r_done, b_hs;
        if (!aresetn) begin
            model_reset();
            return;
        end
        ar_ok  = enable_i && (mr < MAX);
        aw_ok  = enable_i && (mw < MAX);
        w_ok   = (mc > 0);
        ar_hs  = s_axi_arvalid && ar_ok && m_axi_arready;
        aw_hs  = s_axi_awvalid && aw_ok && m_axi_awready;
        w_done = s_axi_wvalid && w_ok && m_axi_wready && s_axi_wlast;
        r_hs   = m_axi_rvalid && s_axi_rready;
        r_done = r_hs && m_axi_rlast;
        b_hs   = m_axi_bvalid && s_axi_bready;
        if ((r_done && mr == 0) || (b_hs && mw == 0)) mproto = 1'b1;
        if (r_hs && m_axi_rresp != 2'b00) merr[0] = 1'b1;
        if (b_hs && m_axi_bresp != 2'b00) merr[1] = 1'b1;
        mr = mr + int'(ar_hs) - int'(r_done); if (mr < 0) mr = 0;
        mw = mw + int'(aw_hs) - int'(b_hs);   if (mw < 0) mw = 0;
        mc = mc + int'(aw_hs) - int'(w_done);
        if (ar_hs) prd++;
        if (aw_hs) pwr++;
        if ((s_axi_arvalid && !ar_ok) || (s_axi_awvalid && !aw_ok) || (s_axi_wvalid && !w_ok)) pst++;
    endtask

    task automatic check_all();
        bit ar_ok, aw_ok, w_ok;
        ar_ok = aresetn && enable_i && (mr < MAX);
        aw_ok = aresetn && enable_i && (mw < MAX);
        w_ok  = aresetn && (mc > 0);
        chk("m_arvalid", 64'(m_axi_arvalid), 64'(s_axi_arvalid && ar_ok));
        chk("s_arready", 64'(s_axi_arready), 64'(m_axi_arready && ar_ok));
        chk("m_awvalid", 64'(m_axi_awvalid), 64'(s_axi_awvalid && aw_ok));
        chk("s_awready", 64'(s_axi_awready), 64'(m_axi_awready && aw_ok));
        chk("m_wvalid",  64'(m_axi_wvalid),  64'(s_axi_wvalid && w_ok));
        chk("s_wready",  64'(s_axi_wready),  64'(m_axi_wready && w_ok));
        chk("m_araddr",  64'(m_axi_araddr),  WIN_BASE + (64'(s_axi_araddr) % WIN_SIZE));
        chk("m_awaddr",  64'(m_axi_awaddr),  WIN_BASE + (64'(s_axi_awaddr) % WIN_SIZE));
        chk("m_arid",    64'(m_axi_arid),    64'(s_axi_arid));
        chk("m_arlen",   64'(m_axi_arlen),   64'(s_axi_arlen));
        chk("m_awid",    64'(m_axi_awid),    64'(s_axi_awid));
        chk("m_wdata",   m_axi_wdata,        s_axi_wdata);
        chk("m_wlast",   64'(m_axi_wlast),   64'(s_axi_wlast));
        chk("s_rvalid",  64'(s_axi_rvalid),  64'(m_axi_rvalid));
        chk("s_rdata",   s_axi_rdata,        m_axi_rdata);
        chk("s_rresp",   64'(s_axi_rresp),   64'(m_axi_rresp));
        chk("m_rready",  64'(m_axi_rready),  64'(s_axi_rready));
        chk("s_bvalid",  64'(s_axi_bvalid),  64'(m_axi_bvalid));
        chk("s_bid",     64'(s_axi_bid),     64'(m_axi_bid));
        chk("m_bready",  64'(m_axi_bready),  64'(s_axi_bready));
        chk("idle",      64'(idle_o),        64'(mr == 0 && mw == 0 && mc == 0));
        chk("err",       64'(err_o),         64'(merr));
        chk("proto",     64'(proto_err_o),   64'(mproto));
`ifdef HP0_AXI_DRAM_GATE_PERF_EN
        chk("rd_bursts", 64'(rd_bursts_o), 64'(prd));
        chk("wr_bursts", 64'(wr_bursts_o), 64'(pwr));
        chk("stall_cyc", 64'(stall_cyc_o), 64'(pst));
`else
        chk("rd_bursts", 64'(rd_bursts_o), 64'd0);
        chk("wr_bursts", 64'(wr_bursts_o), 64'd0);
        chk("stall_cyc", 64'(stall_cyc_o), 64'd0);
`endif
    endtask

    task automatic settle();
        @(negedge aclk);
    endtask

    task automatic adv();
        check_all();
        @(posedge aclk);
        model_update();
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin settle(); adv(); end
    endtask

    task automatic quiet();
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_rresp = 2'b00; m_axi_bresp = 2'b00;
    endtask

    task automatic rand_traffic(input int en_pct);
        enable_i      = ($urandom % 100) < en_pct;
        s_axi_arvalid = ($urandom % 2) == 0;
        s_axi_araddr  = $urandom;
        s_axi_arid    = 6'($urandom);
        s_axi_arlen   = 8'($urandom);
        s_axi_awvalid = ($urandom % 2) == 0;
        s_axi_awaddr  = $urandom;
        s_axi_awid    = 6'($urandom);
        s_axi_wvalid  = ($urandom % 2) == 0;
        s_axi_wlast   = ($urandom % 3) == 0;
        s_axi_wdata   = {$urandom, $urandom};
        s_axi_wstrb   = 8'($urandom);
        m_axi_arready = ($urandom % 4) != 0;
        m_axi_awready = ($urandom % 4) != 0;
        m_axi_wready  = ($urandom % 4) != 0;
        m_axi_rvalid  = (mr > 0) && (($urandom % 2) == 0);
        m_axi_rlast   = ($urandom % 2) == 0;
        m_axi_rresp   = (($urandom % 8) == 0) ? 2'b10 : 2'b00;
        m_axi_rdata   = {$urandom, $urandom};
        m_axi_rid     = 6'($urandom);
        m_axi_bvalid  = (mw > mc) && (($urandom % 2) == 0);
        m_axi_bresp   = (($urandom % 8) == 0) ? 2'b11 : 2'b00;
        m_axi_bid     = 6'($urandom);
        s_axi_rready  = ($urandom % 4) != 0;
        s_axi_bready  = ($urandom % 4) != 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int guard;
        aresetn = 1'b0; enable_i = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = 8'd3; s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
        s_axi_awlock = 1'b0; s_axi_awcache = 4'h3; s_axi_awprot = 3'b000; s_axi_awqos = 4'h0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = 8'd3; s_axi_arsize = 3'd3; s_axi_arburst = 2'b01;
        s_axi_arlock = 1'b0; s_axi_arcache = 4'h3; s_axi_arprot = 3'b000; s_axi_arqos = 4'h0;
        s_axi_wdata = '0; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
        m_axi_bid = '0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        m_axi_arready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        quiet();
        s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;

        // Reset: all request valids held high must stay closed.
        settle();
        chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst_m_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_m_wvalid",  64'(m_axi_wvalid),  64'd0);
        chk("rst_s_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_idle",      64'(idle_o),        64'd1);
        chk("rst_err",       64'(err_o),         64'd0);
        chk("rst_proto",     64'(proto_err_o),   64'd0);
        adv();
        aresetn = 1'b1; quiet();
        cyc(2);

        // Rebase on AR, then fill the read window.
        s_axi_araddr = 32'h0000_1040; s_axi_arvalid = 1'b1;
        settle();
        chk("rebase_ar", 64'(m_axi_araddr), 64'h1000_1040);
        chk("rebase_ar_rdy", 64'(s_axi_arready), 64'd1);
        adv();
        for (int i = 0; i < 7; i++) begin
            s_axi_araddr = $urandom;
            cyc(1);
        end
        settle();
        chk("ar_limit_rdy", 64'(s_axi_arready), 64'd0);
        chk("ar_limit_vld", 64'(m_axi_arvalid), 64'd0);
        adv();
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        settle();
        chk("ar_limit_same_cycle", 64'(s_axi_arready), 64'd0);
        adv();
        m_axi_rvalid = 1'b0;
        settle();
        chk("ar_unblock_next", 64'(s_axi_arready), 64'd1);
        adv();
        s_axi_arvalid = 1'b0;

        // Non-OKAY read response sets a sticky flag.
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rresp = 2'b10;
        cyc(1);
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
        settle();
        chk("rresp_err", 64'(err_o), 64'h1);
        adv();
        cyc(3);
        settle();
        chk("rresp_err_sticky", 64'(err_o), 64'h1);
        adv();

        // W presented before its AW is held until the cycle after the AW handshake.
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1; s_axi_wdata = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("w_before_aw_vld", 64'(m_axi_wvalid), 64'd0);
            chk("w_before_aw_rdy", 64'(s_axi_wready), 64'd0);
            adv();
        end
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'hF234_5678;
        settle();
        chk("rebase_aw", 64'(m_axi_awaddr), 64'h1234_5678);
        chk("w_same_as_aw", 64'(m_axi_wvalid), 64'd0);
        chk("aw_rdy", 64'(s_axi_awready), 64'd1);
        adv();
        s_axi_awvalid = 1'b0;
        settle();
        chk("w_after_aw", 64'(m_axi_wvalid), 64'd1);
        adv();
        s_axi_wvalid = 1'b0;

        // Drain with 3 reads and 2 writes outstanding.
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
        cyc(4);
        m_axi_rvalid = 1'b0;
        s_axi_awvalid = 1'b1;
        cyc(1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
        cyc(1);
        s_axi_wvalid = 1'b0;
        enable_i = 1'b0; s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
        settle();
        chk("drain_ar_refused", 64'(s_axi_arready), 64'd0);
        chk("drain_aw_refused", 64'(s_axi_awready), 64'd0);
        chk("drain_not_idle", 64'(idle_o), 64'd0);
        adv();
        m_axi_rvalid = 1'b1;
        cyc(3);
        m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b1;
        cyc(1);
        settle();
        chk("drain_last_b_cycle", 64'(idle_o), 64'd0);
        adv();
        m_axi_bvalid = 1'b0;
        settle();
        chk("drain_idle", 64'(idle_o), 64'd1);
        chk("drain_no_proto", 64'(proto_err_o), 64'd0);
        adv();
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;

        // Stray B with no write outstanding.
        m_axi_bvalid = 1'b1;
        cyc(1);
        m_axi_bvalid = 1'b0;
        settle();
        chk("stray_b_proto", 64'(proto_err_o), 64'd1);
        chk("stray_b_idle", 64'(idle_o), 64'd1);
        adv();

        // Perf: 5 AR handshakes, then 7 gated cycles.
        aresetn = 1'b0;
        cyc(2);
        aresetn = 1'b1; enable_i = 1'b1; s_axi_arvalid = 1'b1;
        settle();
        chk("post_rst_proto", 64'(proto_err_o), 64'd0);
        chk("post_rst_err", 64'(err_o), 64'd0);
        adv();
        cyc(4);
        enable_i = 1'b0;
        cyc(7);
        s_axi_arvalid = 1'b0;
        settle();
`ifdef HP0_AXI_DRAM_GATE_PERF_EN
        chk("perf_rd_bursts", 64'(rd_bursts_o), 64'd5);
        chk("perf_stall", 64'(stall_cyc_o), 64'd7);
`else
        chk("perf_rd_bursts_off", 64'(rd_bursts_o), 64'd0);
        chk("perf_stall_off", 64'(stall_cyc_o), 64'd0);
`endif
        adv();

        // Random traffic with mostly-enabled gating.
        for (int i = 0; i < 800; i++) begin
            rand_traffic(90);
            cyc(1);
        end

        // Random drain: no new requests accepted, everything outstanding completes.
        guard = 0;
        while (!(mr == 0 && mw == 0 && mc == 0) && guard < 3000) begin
            rand_traffic(0);
            cyc(1);
            guard++;
        end
        quiet();
        settle();
        chk("rand_drain_model_idle", 64'(mr == 0 && mw == 0 && mc == 0), 64'd1);
        chk("rand_drain_idle", 64'(idle_o), 64'd1);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
